// File: rtl/fpga_pll_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies synchronized lock, retries on timeout.
// Optional lock-loss statistics counter is enabled with `define FPGA_PLL_SUP_STATS_EN.
module fpga_pll_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 20000,
    parameter int SETTLE_CYCLES    = 256,
    parameter int MAX_RETRIES      = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pll_locked,
    output logic                               pll_rst_n,
    output logic                               pll_ok,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic                               fail,
    output logic [7:0]                         lock_loss_cnt
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX_A = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_MAX = (CNT_MAX_A > RST_PULSE_CYCLES) ? CNT_MAX_A : RST_PULSE_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LOAD   = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_RESET  = CW'(RST_PULSE_CYCLES);
    localparam logic [CW-1:0] WAIT_LOAD   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [RW-1:0]   retry_q, retry_d, retry_inc;
    logic [1:0]      sync_q;
    logic            locked_s;
    logic            lock_lost_d;

    assign locked_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);

    always_comb begin
        state_d     = state;
        cnt_d       = (cnt == '0) ? cnt : cnt - CW'(1);
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        case (state)
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT_LOCK: begin
                // lock takes priority over a timeout landing on the same edge
                if (locked_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else if (cnt == '0) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_SETTLE: begin
                if (!locked_s) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = ST_HOLD;
                    cnt_d       = HOLD_LOAD;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
            end
        endcase
    end

    // Reset preloads one extra count so the first non-reset edge acts as HOLD entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HOLD;
            cnt       <= HOLD_RESET;
            retry_q   <= '0;
            pll_rst_n <= 1'b0;
            pll_ok    <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_n <= (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
            pll_ok    <= (state_d == ST_RUN);
            lock_lost <= lock_lost_d;
            fail      <= (state_d == ST_FAIL);
        end
    end

    assign retry_cnt = retry_q;

`ifdef FPGA_PLL_SUP_STATS_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= 8'd0;
        end else if (lock_lost_d && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fpga_pll_supervisor.sv
// Bench for fpga_pll_supervisor: directed and random lock waveforms against an attempt-level schedule model.
module tb_fpga_pll_supervisor;

    localparam int P    = 4;
    localparam int T    = 50;
    localparam int S    = 8;
    localparam int MAXR = 2;
    localparam int MAXN = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst_n, pll_ok, lock_lost, fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int tests = 0;
    int fails = 0;
    int n_cur = 0;

    logic lk      [MAXN];
    logic exp_rn  [MAXN];
    logic exp_ok  [MAXN];
    logic exp_fl  [MAXN];
    logic exp_lost[MAXN];
    int   exp_rt  [MAXN];
    int   exp_lc  [MAXN];

    fpga_pll_supervisor #(
        .RST_PULSE_CYCLES(P),
        .LOCK_TIMEOUT(T),
        .SETTLE_CYCLES(S),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst_n(pll_rst_n),
        .pll_ok(pll_ok),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt),
        .fail(fail),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    task automatic set_lk(input int a, input int b, input logic v);
        for (int c = a; c < b && c < MAXN; c++) lk[c] = v;
    endtask

    // locked_s during cycle c follows pll_locked driven two cycles earlier
    function automatic logic ls(input int c);
        if (c < 2 || c - 2 >= MAXN) return 1'b0;
        return lk[c-2];
    endfunction

    task automatic fill(input int a, input int b, input logic rn, input logic ok, input logic fl,
                        input int rt, input int lc);
        for (int c = a; c < b && c < n_cur; c++) begin
            exp_rn[c] = rn;
            exp_ok[c] = ok;
            exp_fl[c] = fl;
            exp_rt[c] = rt;
            exp_lc[c] = lc;
        end
    endtask

    // Schedule model: walk attempts (hold pulse, lock wait, settle window, run) over the lock waveform.
    task automatic build_model(input int n);
        int t, w, s, a, r, d, retry, loss;
        bit done;
        n_cur = n;
        for (int c = 0; c < MAXN; c++) exp_lost[c] = 1'b0;
        t = 0; retry = 0; loss = 0; done = 0;
        while (!done && t < n) begin
            w = t + P;
            fill(t, w, 1'b0, 1'b0, 1'b0, retry, loss);
            s = -1;
            for (int e = w + 1; e <= w + T; e++) if (s < 0 && ls(e - 1)) s = e;
            if (s < 0) begin
                fill(w, w + T, 1'b1, 1'b0, 1'b0, retry, loss);
                retry++;
                if (retry == MAXR) begin
                    fill(w + T, n, 1'b0, 1'b0, 1'b1, retry, loss);
                    done = 1;
                end else begin
                    t = w + T;
                end
            end else begin
                fill(w, s, 1'b1, 1'b0, 1'b0, retry, loss);
                a = -1;
                for (int e = s + 1; e <= s + S; e++) if (a < 0 && !ls(e - 1)) a = e;
                if (a >= 0) begin
                    fill(s, a, 1'b1, 1'b0, 1'b0, retry, loss);
                    retry++;
                    if (retry == MAXR) begin
                        fill(a, n, 1'b0, 1'b0, 1'b1, retry, loss);
                        done = 1;
                    end else begin
                        t = a;
                    end
                end else begin
                    r = s + S;
                    fill(s, r, 1'b1, 1'b0, 1'b0, retry, loss);
                    d = -1;
                    for (int e = r + 1; e < n && d < 0; e++) if (!ls(e - 1)) d = e;
                    if (d < 0) begin
                        fill(r, n, 1'b1, 1'b1, 1'b0, retry, loss);
                        done = 1;
                    end else begin
                        fill(r, d, 1'b1, 1'b1, 1'b0, retry, loss);
                        exp_lost[d] = 1'b1;
`ifdef FPGA_PLL_SUP_STATS_EN
                        if (loss < 255) loss++;
`endif
                        t = d;
                    end
                end
            end
        end
    endtask

    // One scenario: a one-cycle reset (checked), then n cycles checked against the model.
    task automatic run_scn(input int n);
        @(negedge clk);
        rst = 1'b1;
        pll_locked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pll_rst_n", -1, 8'(pll_rst_n), 8'd0);
        chk("rst_pll_ok", -1, 8'(pll_ok), 8'd0);
        chk("rst_lock_lost", -1, 8'(lock_lost), 8'd0);
        chk("rst_retry_cnt", -1, 8'(retry_cnt), 8'd0);
        chk("rst_fail", -1, 8'(fail), 8'd0);
        chk("rst_lock_loss_cnt", -1, lock_loss_cnt, 8'd0);
        rst = 1'b0;
        build_model(n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("pll_rst_n", c, 8'(pll_rst_n), 8'(exp_rn[c]));
            chk("pll_ok", c, 8'(pll_ok), 8'(exp_ok[c]));
            chk("lock_lost", c, 8'(lock_lost), 8'(exp_lost[c]));
            chk("retry_cnt", c, 8'(retry_cnt), 8'(exp_rt[c]));
            chk("fail", c, 8'(fail), 8'(exp_fl[c]));
            chk("lock_loss_cnt", c, lock_loss_cnt, 8'(exp_lc[c]));
            pll_locked = lk[c];
        end
    endtask

    initial begin
        int c0, len;
        logic lvl;

        // clean lock: pll_locked rises at cycle 10
        set_lk(0, MAXN, 1'b0); set_lk(10, MAXN, 1'b1);
        run_scn(40);

        // timeout then lock 5 cycles after the second reset release (cycle 58)
        set_lk(0, MAXN, 1'b0); set_lk(63, MAXN, 1'b1);
        run_scn(100);

        // exhaustion: never locks
        set_lk(0, MAXN, 1'b0);
        run_scn(130);

        // settle glitch: high 5, low 1, high
        set_lk(0, MAXN, 1'b0); set_lk(10, 15, 1'b1); set_lk(16, MAXN, 1'b1);
        run_scn(80);

        // lock loss in RUN, then relock
        set_lk(0, MAXN, 1'b0); set_lk(10, 30, 1'b1); set_lk(40, MAXN, 1'b1);
        run_scn(80);

        // lock arrives on the very edge the wait window expires
        set_lk(0, MAXN, 1'b0); set_lk(T + 1, MAXN, 1'b1);
        run_scn(80);

        // run stops mid-settle; the next scenario's reset lands there
        set_lk(0, MAXN, 1'b0); set_lk(10, MAXN, 1'b1);
        run_scn(16);

        for (int k = 0; k < 10; k++) begin
            set_lk(0, MAXN, 1'b0);
            c0 = $urandom_range(0, 20);
            lvl = 1'b1;
            while (c0 < 220) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
                set_lk(c0, c0 + len, lvl);
                c0 = c0 + len;
                lvl = ~lvl;
            end
            run_scn(220);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpga_pll_supervisor.md
# fpga_pll_supervisor

PLL reset/lock supervisor on the 200 MHz reference clock, directly upstream of the 80 MHz system PLL. It drives the PLL's active-low reset and synchronizes the PLL's asynchronous lock flag. It then qualifies lock over a settle window and retries the PLL on lock timeout. `pll_ok` and a sticky `fail` are exported to the board-level reset tree, which gates release of the system clock domain reset.

## Interface
- `RST_PULSE_CYCLES`, 16 — cycles `pll_rst_n` is held low per attempt (≥1).
- `LOCK_TIMEOUT`, 20000 — cycles allowed from PLL reset release to synchronized lock (100 µs @ 200 MHz).
- `SETTLE_CYCLES`, 256 — cycles synchronized lock must stay high before `pll_ok`.
- `MAX_RETRIES`, 7 — failed attempts tolerated before entering FAIL.
- `clk` — in, 1 — 200 MHz reference clock; the only clock.
- `rst` — in, 1 — synchronous, active-high reset.
- `pll_locked` — in, 1 — PLL lock flag, asynchronous to `clk`.
- `pll_rst_n` — out, 1 — active-low reset to the PLL.
- `pll_ok` — out, 1 — PLL locked and qualified.
- `lock_lost` — out, 1 — one-cycle pulse when lock drops while in RUN.
- `retry_cnt` — out, $clog2(MAX_RETRIES+1) — failed attempts since `rst`, saturating.
- `fail` — out, 1 — sticky; set when `retry_cnt` reaches `MAX_RETRIES`.
- `lock_loss_cnt` — out, 8 — lock-loss event count; see Configuration.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to produce `locked_s`. No other logic samples `pll_locked`.
- One shared down-counter `cnt`, reloaded on every state entry.
- **HOLD**
  - `pll_rst_n`=0, `cnt`=`RST_PULSE_CYCLES`-1.
  - Transitions to WAIT_LOCK when `cnt`==0.
- **WAIT_LOCK**
  - `pll_rst_n`=1.
  - `locked_s`=1: go to SETTLE.
  - Else, if `cnt` expires: `retry_cnt`++. Then go to FAIL if the new value equals `MAX_RETRIES`, otherwise to HOLD.
- **SETTLE**
  - `locked_s` must remain 1 for `SETTLE_CYCLES` consecutive cycles; then go to RUN.
  - If `locked_s`=0 at any point: `retry_cnt`++, then FAIL/HOLD by the same rule as WAIT_LOCK.
- **RUN**
  - `pll_ok`=1.
  - `locked_s`=0: pulse `lock_lost`, go to HOLD, clear `pll_ok` on the same edge.
  - A lock loss does not increment `retry_cnt`.
- **FAIL**
  - `pll_rst_n`=0, `pll_ok`=0, `fail`=1.
  - Terminal; only `rst` exits.
- Simultaneous `cnt` expiry and `locked_s`=1 in WAIT_LOCK: lock wins, go to SETTLE, no retry counted.
- `rst` asserted in any state, including mid-SETTLE or RUN, forces the reset values on the next edge:
  - state=HOLD, `pll_rst_n`=0, `pll_ok`=0, `lock_lost`=0, `retry_cnt`=0, `fail`=0, `lock_loss_cnt`=0.
  - Synchronizer flops reset to 0.
- All outputs are registered, and there is no combinational path from input to output.

## Timing
- Reset release to `pll_rst_n` rising: exactly `RST_PULSE_CYCLES` cycles. HOLD is entered on the first non-reset edge.
- `pll_locked` rise to `locked_s`: 2 cycles.
- `locked_s` rise to `pll_ok` rise: `SETTLE_CYCLES`+1 cycles (SETTLE entry plus window).
- Lock drop in RUN:
  - `lock_lost` pulse and `pll_ok` fall occur 3 cycles after `pll_locked` falls (2 sync + 1 register).
  - `pll_rst_n` falls on the same cycle.
- Timeout: `retry_cnt` updates on the edge leaving WAIT_LOCK, `LOCK_TIMEOUT` cycles after `pll_rst_n` rose.
- `fail` rises on the same edge as the final `retry_cnt` increment.

## Configuration
- Macro: `FPGA_PLL_SUP_STATS_EN`.
- Defined: `lock_loss_cnt` increments on every `lock_lost` pulse and saturates at 255.
- Undefined: the port remains and is tied to 8'd0; no counter logic is generated.

## Test plan
Bench parameters: `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT`=50, `SETTLE_CYCLES`=8, `MAX_RETRIES`=2. Cycle 0 = first edge after `rst` deasserts.
- **Clean lock:** `pll_locked` rises at cycle 10 → `pll_rst_n`=1 from cycle 4; `pll_ok`=1 at cycle 21; `retry_cnt`=0.
- **Timeout then lock:** `pll_locked` stays 0 through the first attempt, then rises 5 cycles after the second `pll_rst_n` release.
  - `retry_cnt`=1 after cycle 54; `pll_rst_n` low for 4 cycles.
  - `pll_ok`=1 eventually; `fail`=0.
- **Exhaustion:** `pll_locked` held 0.
  - `retry_cnt`=1, then 2; `fail`=1 on the second timeout.
  - `pll_rst_n` stays 0 and `pll_ok`=0 until `rst`.
- **Settle glitch:** `pll_locked` high 5 cycles, low 1, high → SETTLE aborts, `retry_cnt`=1, new HOLD pulse of 4 cycles.
- **Lock loss in RUN:** `pll_locked` falls → `lock_lost` high for exactly 1 cycle and `pll_ok`=0, both 3 cycles later.
  - `retry_cnt` unchanged.
  - With `FPGA_PLL_SUP_STATS_EN`, `lock_loss_cnt`=1; without it, 0.
- **Reset mid-SETTLE:** `rst` asserted for 1 cycle → all outputs at reset values the next cycle; the sequence restarts from HOLD.
